// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding, ACK/NACK bit levels, default target address.
// Also pulled in by i2c_master benches so both ends agree on the address.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_state_t;

    localparam logic       I2C_ACK          = 1'b0;
    localparam logic       I2C_NACK         = 1'b1;
    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h55;

    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] own_addr);
        return addr_byte[7:1] == own_addr;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronisers and bus event detection; events are valid 2 clk after a pin change.
// Pure observer of the bus, so it has no flow control.
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic       scl_s;

    // Reset to the idle-bus level so releasing reset never fakes an edge while SCL is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with an auto-incrementing byte register file and a local side port.
// Pin-to-action latency 3 clk; never stretches SCL, so the controller sets the pace.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR       = I2C_DEFAULT_ADDR,
    parameter int         DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    input  logic                  loc_we,
    input  logic [DEPTH_LOG2-1:0] loc_addr,
    input  logic [7:0]            loc_wdata,
    output logic [7:0]            loc_rdata,
    output logic                  wr_strobe,
    output logic [DEPTH_LOG2-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    i2c_line_sync u_line_sync (
        .clk       (clk),
        .rst_n     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_state_t            state_q;
    logic [2:0]            bit_cnt_q;
    logic [7:0]            shift_q;
    logic [DEPTH_LOG2-1:0] ptr_q;
    logic                  ack_phase_q;
    logic                  rw_q;
    logic [7:0]            regs_q [DEPTH];

    logic [7:0] shift_d;
    logic       last_bit;
    logic       bus_we;

    assign shift_d  = {shift_q[6:0], sda_s};
    assign last_bit = (bit_cnt_q == 3'd7);
    assign bus_we   = (state_q == ST_WDATA) && scl_rise && last_bit && !start_det && !stop_det;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            ack_phase_q <= 1'b0;
            rw_q        <= 1'b0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (stop_det) begin
                state_q     <= ST_IDLE;
                sda_oe      <= 1'b0;
                busy        <= 1'b0;
                ack_phase_q <= 1'b0;
            end else if (start_det) begin
                // Also the repeated-START path: abandon whatever byte was in flight.
                state_q     <= ST_ADDR;
                bit_cnt_q   <= '0;
                sda_oe      <= 1'b0;
                ack_phase_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (last_bit) begin
                                if (addr_match(shift_d, ADDR)) begin
                                    state_q <= ST_ADDR_ACK;
                                    rw_q    <= shift_d[0];
                                    busy    <= 1'b1;
                                end else begin
                                    state_q <= ST_IDLE;
                                    busy    <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_PTR: begin
                        if (scl_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (last_bit) begin
                                ptr_q   <= shift_d[DEPTH_LOG2-1:0];
                                state_q <= ST_PTR_ACK;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (scl_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (last_bit) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= ptr_q;
                                wr_data   <= shift_d;
                                state_q   <= ST_WDATA_ACK;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                        // First fall ends bit 8 and starts the ACK; second fall ends the ACK.
                        if (scl_fall) begin
                            if (!ack_phase_q) begin
                                sda_oe      <= ~I2C_ACK;
                                ack_phase_q <= 1'b1;
                            end else begin
                                ack_phase_q <= 1'b0;
                                bit_cnt_q   <= '0;
                                sda_oe      <= 1'b0;
                                if (state_q == ST_ADDR_ACK) begin
                                    if (rw_q) begin
                                        state_q <= ST_RDATA;
                                        shift_q <= regs_q[ptr_q];
                                        sda_oe  <= ~regs_q[ptr_q][7];
                                    end else begin
                                        state_q <= ST_PTR;
                                    end
                                end else begin
                                    state_q <= ST_WDATA;
                                    if (state_q == ST_WDATA_ACK) begin
                                        ptr_q <= ptr_q + DEPTH_LOG2'(1);
                                    end
                                end
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (scl_fall) begin
                            if (last_bit) begin
                                sda_oe    <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= ST_RDATA_ACK;
                            end else begin
                                sda_oe    <= ~shift_q[6];
                                shift_q   <= {shift_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_rise) begin
                            ptr_q <= ptr_q + DEPTH_LOG2'(1);
                            if (sda_s == I2C_NACK) begin
                                state_q <= ST_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                ack_phase_q <= 1'b1;
                            end
                        end else if (scl_fall && ack_phase_q) begin
                            // ptr_q already advanced on the ACK rise, so this fetches the next byte.
                            ack_phase_q <= 1'b0;
                            bit_cnt_q   <= '0;
                            state_q     <= ST_RDATA;
                            shift_q     <= regs_q[ptr_q];
                            sda_oe      <= ~regs_q[ptr_q][7];
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Bus commit is applied after the local write so it wins a same-address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (loc_we) begin
                regs_q[loc_addr] <= loc_wdata;
            end
            if (bus_we) begin
                regs_q[ptr_q] <= shift_d;
            end
        end
    end

    assign loc_rdata = regs_q[loc_addr];

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bus-level bench for i2c_target_regfile: bit-banged controller, register-file reference model,
// and a scoreboard monitor that owns every comparison.
module tb_i2c_target_regfile;

    localparam int         Q  = 5;
    localparam logic [6:0] TA = 7'h55;
    localparam logic [7:0] AW = {TA, 1'b0};
    localparam logic [7:0] AR = {TA, 1'b1};

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       scl_m     = 1'b1;
    logic       sda_m     = 1'b1;
    logic       loc_we    = 1'b0;
    logic [3:0] loc_addr  = 4'd0;
    logic [7:0] loc_wdata = 8'd0;
    logic       sda_oe;
    logic [7:0] loc_rdata;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    wire        sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regfile #(.ADDR(TA), .DEPTH_LOG2(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_m),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .loc_we    (loc_we),
        .loc_addr  (loc_addr),
        .loc_wdata (loc_wdata),
        .loc_rdata (loc_rdata),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    typedef struct {
        string       name;
        logic [7:0]  val;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    exp_t        exp_q[$];
    logic [7:0]  act_q[$];
    logic [11:0] exp_wr_q[$];
    chk_t        dir_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int oe_cnt      = 0;
    int busy_cnt    = 0;

    logic [7:0] model_regs [16];
    int         model_ptr;
    logic [7:0] wbuf [4];

    function automatic void compare(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", n, a, e);
        end
    endfunction

    // Scoreboard monitor: the only process that compares or counts.
    exp_t        m_exp;
    logic [7:0]  m_act;
    logic [11:0] m_wr;
    chk_t        m_chk;
    always @(negedge clk) begin
        if (sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
        if (wr_strobe) begin
            if (exp_wr_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wr_spurious: got addr %0h data %0h, expected no commit", wr_addr, wr_data);
            end else begin
                m_wr = exp_wr_q.pop_front();
                compare("wr_commit", {20'd0, wr_addr, wr_data}, {20'd0, m_wr});
            end
        end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            m_act = act_q.pop_front();
            m_exp = exp_q.pop_front();
            compare(m_exp.name, {24'd0, m_act}, {24'd0, m_exp.val});
        end
        while (dir_q.size() > 0) begin
            m_chk = dir_q.pop_front();
            compare(m_chk.name, m_chk.act, m_chk.exp);
        end
    end

    function automatic void dchk(input string n, input logic [31:0] a, input logic [31:0] e);
        chk_t c;
        c.name = n;
        c.act  = a;
        c.exp  = e;
        dir_q.push_back(c);
    endfunction

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic coll);
        wq(Q); sda_m = b; wq(Q); scl_m = 1'b1;
        if (coll) begin
            // Local write lands on the same edge as the bus commit (3 clk after the SCL rise).
            wq(2); loc_we = 1'b1; wq(1); loc_we = 1'b0; wq(2*Q - 3);
        end else begin
            wq(2*Q);
        end
        scl_m = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        wq(Q); sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q); b = sda_line; wq(Q); scl_m = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] d, input int n, input logic coll);
        for (int i = 7; i > 7 - n; i--) send_bit(d[i], coll && (i == 0));
    endtask

    task automatic start_c;
        sda_m = 1'b0; wq(2*Q); scl_m = 1'b0;
    endtask

    task automatic rstart_c;
        wq(Q); sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b0; wq(Q); scl_m = 1'b0;
    endtask

    task automatic stop_c;
        wq(Q); sda_m = 1'b0; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b1; wq(2*Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input logic coll);
        exp_t e;
        logic a;
        e.name = "ack";
        e.val  = {7'd0, exp_ack};
        exp_q.push_back(e);
        send_bits(d, 8, coll);
        get_bit(a);
        act_q.push_back({7'd0, a});
    endtask

    task automatic read_byte(input logic [7:0] exp_d, input logic mack);
        exp_t e;
        logic [7:0] d;
        logic b;
        e.name = "rdata";
        e.val  = exp_d;
        exp_q.push_back(e);
        d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            get_bit(b);
            d = {d[6:0], b};
        end
        act_q.push_back(d);
        send_bit(mack, 1'b0);
    endtask

    task automatic txn_write(input logic [7:0] p, input int n);
        start_c;
        write_byte(AW, 1'b0, 1'b0);
        write_byte(p, 1'b0, 1'b0);
        model_ptr = p % 16;
        for (int i = 0; i < n; i++) begin
            exp_wr_q.push_back({model_ptr[3:0], wbuf[i]});
            model_regs[model_ptr] = wbuf[i];
            write_byte(wbuf[i], 1'b0, 1'b0);
            model_ptr = (model_ptr + 1) % 16;
        end
        stop_c;
    endtask

    task automatic txn_read(input logic set_ptr, input logic [7:0] p, input int n);
        start_c;
        if (set_ptr) begin
            write_byte(AW, 1'b0, 1'b0);
            write_byte(p, 1'b0, 1'b0);
            model_ptr = p % 16;
            rstart_c;
        end
        write_byte(AR, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            read_byte(model_regs[model_ptr], (i == n - 1));
            model_ptr = (model_ptr + 1) % 16;
        end
        dchk("busy_after_nack", busy, 0);
        dchk("sda_released_after_nack", sda_oe, 0);
        stop_c;
    endtask

    task automatic loc_write(input int a, input logic [7:0] d);
        loc_addr = a[3:0]; loc_wdata = d; loc_we = 1'b1; wq(1); loc_we = 1'b0;
        model_regs[a] = d;
    endtask

    task automatic loc_chk(input string n, input int a);
        loc_addr = a[3:0];
        #1;
        dchk(n, loc_rdata, model_regs[a]);
        wq(1);
    endtask

    task automatic txn_collide(input logic [3:0] p, input logic [7:0] bd, input logic [3:0] la, input logic [7:0] ld);
        start_c;
        write_byte(AW, 1'b0, 1'b0);
        write_byte({4'd0, p}, 1'b0, 1'b0);
        loc_addr  = la;
        loc_wdata = ld;
        model_regs[la] = ld;
        model_regs[p]  = bd;
        exp_wr_q.push_back({p, bd});
        write_byte(bd, 1'b0, 1'b1);
        model_ptr = (p + 1) % 16;
        stop_c;
        loc_chk("collide_bus_reg", p);
        loc_chk("collide_loc_reg", la);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int oe0, busy0, op, n;
        logic [7:0] p;
        logic [6:0] wa;
        logic dummy;

        for (int i = 0; i < 16; i++) model_regs[i] = 8'd0;
        model_ptr = 0;

        wq(3);
        #1;
        dchk("rst_sda_oe", sda_oe, 0);
        dchk("rst_busy", busy, 0);
        dchk("rst_wr_strobe", wr_strobe, 0);
        dchk("rst_wr_addr", wr_addr, 0);
        dchk("rst_wr_data", wr_data, 0);
        dchk("rst_reg0", loc_rdata, 0);
        wq(1);
        reset = 1'b1;
        wq(3);

        // Basic write: ptr 2, data 0x80 then 0xC0.
        wbuf[0] = 8'h80; wbuf[1] = 8'hC0;
        txn_write(8'h02, 2);
        loc_addr = 4'd2; #1; dchk("write_reg2", loc_rdata, 8'h80); wq(1);
        loc_addr = 4'd3; #1; dchk("write_reg3", loc_rdata, 8'hC0); wq(1);
        dchk("busy_after_stop", busy, 0);

        // Read across the top of the register file with repeated START.
        loc_write(14, 8'h7F);
        loc_write(15, 8'hFF);
        txn_read(1'b1, 8'h0E, 3);

        // Foreign address: bus must stay untouched.
        oe0 = oe_cnt; busy0 = busy_cnt;
        start_c;
        write_byte(8'hA8, 1'b1, 1'b0);
        stop_c;
        dchk("mismatch_sda_oe_cycles", oe_cnt - oe0, 0);
        dchk("mismatch_busy_cycles", busy_cnt - busy0, 0);

        // STOP after 4 data bits: no commit, then a clean transaction.
        start_c;
        write_byte(AW, 1'b0, 1'b0);
        write_byte(8'h04, 1'b0, 1'b0);
        model_ptr = 4;
        send_bits(8'h5A, 4, 1'b0);
        stop_c;
        dchk("midstop_busy", busy, 0);
        dchk("midstop_sda_oe", sda_oe, 0);
        loc_chk("midstop_reg4", 4);
        wbuf[0] = 8'h3C;
        txn_write(8'h04, 1);
        loc_chk("after_midstop_reg4", 4);

        // Reset while the address ACK is being driven.
        start_c;
        send_bits(AW, 8, 1'b0);
        for (int i = 0; i < 12 && !sda_oe; i++) wq(1);
        dchk("addr_ack_driven", sda_oe, 1);
        loc_addr = 4'd2;
        reset = 1'b0;
        #1;
        dchk("midrst_sda_oe", sda_oe, 0);
        dchk("midrst_busy", busy, 0);
        dchk("midrst_wr_strobe", wr_strobe, 0);
        dchk("midrst_wr_addr", wr_addr, 0);
        dchk("midrst_wr_data", wr_data, 0);
        dchk("midrst_reg2", loc_rdata, 0);
        for (int i = 0; i < 16; i++) model_regs[i] = 8'd0;
        model_ptr = 0;
        wq(2);
        reset = 1'b1;
        get_bit(dummy);
        stop_c;

        // Collision with the bus commit: same register, then a different one.
        txn_collide(4'd5, 8'hA5, 4'd5, 8'h11);
        txn_collide(4'd6, 8'h96, 4'd9, 8'h22);

        // Randomised traffic against the reference model.
        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 4);
            n  = $urandom_range(1, 4);
            p  = 8'($urandom_range(0, 255));
            case (op)
                0: begin
                    loc_write($urandom_range(0, 15), 8'($urandom_range(0, 255)));
                    loc_chk("rand_loc_rdata", $urandom_range(0, 15));
                end
                1: begin
                    for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
                    txn_write(p, n);
                end
                2: txn_read(1'b1, p, n);
                3: txn_read(1'b0, p, n);
                default: begin
                    wa = 7'($urandom_range(0, 127));
                    if (wa == TA) wa = wa ^ 7'h01;
                    oe0 = oe_cnt;
                    start_c;
                    write_byte({wa, 1'($urandom_range(0, 1))}, 1'b1, 1'b0);
                    stop_c;
                    dchk("rand_mismatch_sda_oe_cycles", oe_cnt - oe0, 0);
                end
            endcase
        end

        for (int i = 0; i < 16; i++) loc_chk("final_reg", i);

        wq(4);
        dchk("exp_q_drained", exp_q.size(), 0);
        dchk("act_q_drained", act_q.size(), 0);
        dchk("exp_wr_q_drained", exp_wr_q.size(), 0);
        wq(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
